// File: rtl/core_test_sequencer.sv
// ---------------------------------------------------------------------------
// core_test_sequencer
//
// Bench-side controller for the core under test. After the harness reset
// releases, it holds the core in reset for RESET_CYCLES clock edges. It then
// lets the core run and counts run cycles. It waits for exactly one completion
// report over a valid/ready handshake. The outcome is latched as pass, fail or
// timeout and held until the next harness reset.
//
// Ports
//   clk           in   1      single clock, all state updates on rising edge
//   reset_l       in   1      asynchronous active-low harness reset
//   core_reset_l  out  1      active-low reset to the core (registered)
//   done_valid    in   1      core presents a completion report
//   done_pass     in   1      completion status, 1 = pass, sampled with valid
//   done_ready    out  1      sequencer can take a report (registered)
//   run_count     out  CNT_W  number of edges spent in RUN
//   state         out  2      0 = HOLD, 1 = RUN, 2 = DONE, 3 = TIMEOUT
//   finished      out  1      sticky, test concluded
//   passed        out  1      sticky, meaningful when finished = 1
//   timed_out     out  1      sticky, run budget expired without a report
// ---------------------------------------------------------------------------
module core_test_sequencer #(
    parameter int RESET_CYCLES   = 4,
    parameter int TIMEOUT_CYCLES = 100,
    parameter int CNT_W          = 32
) (
    input  logic             clk,
    input  logic             reset_l,
    output logic             core_reset_l,
    input  logic             done_valid,
    input  logic             done_pass,
    output logic             done_ready,
    output logic [CNT_W-1:0] run_count,
    output logic [1:0]       state,
    output logic             finished,
    output logic             passed,
    output logic             timed_out
);

    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        RUN     = 2'd1,
        DONE    = 2'd2,
        TIMEOUT = 2'd3
    } state_t;

    // The hold counter only needs to reach RESET_CYCLES-1.
    localparam int HOLD_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0]  RUN_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t            state_q;
    state_t            state_d;
    logic [HOLD_W-1:0] hold_q;
    logic [HOLD_W-1:0] hold_d;
    logic [CNT_W-1:0]  run_count_d;
    logic              core_reset_l_d;
    logic              done_ready_d;
    logic              finished_d;
    logic              passed_d;
    logic              timed_out_d;
    logic              transfer;
    logic              run_expired;

    assign state = state_q;

    // done_ready is only ever 1 in RUN, so this also masks reports that
    // arrive during HOLD or after the result has been latched.
    assign transfer    = done_valid && done_ready;
    assign run_expired = (run_count == RUN_LAST);

    // State register. Every output is registered here so the core and the
    // harness see glitch-free signals, and reset forces them asynchronously.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state_q      <= HOLD;
            hold_q       <= '0;
            run_count    <= '0;
            core_reset_l <= 1'b0;
            done_ready   <= 1'b0;
            finished     <= 1'b0;
            passed       <= 1'b0;
            timed_out    <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            run_count    <= run_count_d;
            core_reset_l <= core_reset_l_d;
            done_ready   <= done_ready_d;
            finished     <= finished_d;
            passed       <= passed_d;
            timed_out    <= timed_out_d;
        end
    end

    // Next-state logic. A report arriving on the last allowed run edge still
    // counts as a completion, so the transfer is tested before the timeout.
    always_comb begin
        state_d = state_q;
        case (state_q)
            HOLD: begin
                if (hold_q == HOLD_LAST) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (transfer) begin
                    state_d = DONE;
                end else if (run_expired) begin
                    state_d = TIMEOUT;
                end
            end
            default: begin
                state_d = state_q;
            end
        endcase
    end

    // Output logic. Computes the next value of every registered output from
    // the current state and the chosen transition. DONE and TIMEOUT keep all
    // outputs as they are, which freezes run_count and the result flags.
    always_comb begin
        hold_d         = hold_q;
        run_count_d    = run_count;
        core_reset_l_d = core_reset_l;
        done_ready_d   = done_ready;
        finished_d     = finished;
        passed_d       = passed;
        timed_out_d    = timed_out;
        case (state_q)
            HOLD: begin
                hold_d = hold_q + HOLD_W'(1);
                if (state_d == RUN) begin
                    core_reset_l_d = 1'b1;
                    done_ready_d   = 1'b1;
                end
            end
            RUN: begin
                // The edge that leaves RUN is still counted as a run cycle.
                run_count_d = run_count + CNT_W'(1);
                if (state_d == DONE) begin
                    finished_d   = 1'b1;
                    passed_d     = done_pass;
                    done_ready_d = 1'b0;
                end else if (state_d == TIMEOUT) begin
                    finished_d   = 1'b1;
                    timed_out_d  = 1'b1;
                    passed_d     = 1'b0;
                    done_ready_d = 1'b0;
                end
            end
            default: begin
                hold_d = hold_q;
            end
        endcase
    end

    // Consistency properties between the core reset and the result flags.
    core_reset_only_in_hold: assert property (
        @(posedge clk) disable iff (!reset_l)
        !core_reset_l |-> (state_q == HOLD)
    );

    flags_need_finished: assert property (
        @(posedge clk) disable iff (!reset_l)
        !finished |-> (!timed_out && !passed)
    );

    timeout_is_not_pass: assert property (
        @(posedge clk) disable iff (!reset_l)
        timed_out |-> !passed
    );

endmodule

// File: tb/tb_core_test_sequencer.sv
// ---------------------------------------------------------------------------
// tb_core_test_sequencer
//
// Self-checking bench for core_test_sequencer. Each driven cycle pushes the
// expected output snapshot onto a scoreboard queue. The snapshot is popped and
// compared one time unit after the following rising edge. Asynchronous reset
// checks are popped and compared shortly after reset_l falls, between edges.
// ---------------------------------------------------------------------------
module tb_core_test_sequencer;

    localparam int CNT_W = 32;

    localparam logic [1:0] ST_HOLD    = 2'd0;
    localparam logic [1:0] ST_RUN     = 2'd1;
    localparam logic [1:0] ST_DONE    = 2'd2;
    localparam logic [1:0] ST_TIMEOUT = 2'd3;

    logic             clk = 1'b0;
    logic             reset_l = 1'b1;
    logic             done_valid = 1'b0;
    logic             done_pass = 1'b0;
    logic             core_reset_l;
    logic             done_ready;
    logic [CNT_W-1:0] run_count;
    logic [1:0]       state;
    logic             finished;
    logic             passed;
    logic             timed_out;

    typedef struct {
        string       tag;
        logic [1:0]  st;
        logic        crl;
        logic        rdy;
        logic [31:0] cnt;
        logic        fin;
        logic        pas;
        logic        tmo;
    } exp_t;

    exp_t sb[$];
    int   checks_total  = 0;
    int   checks_passed = 0;

    core_test_sequencer #(
        .RESET_CYCLES  (4),
        .TIMEOUT_CYCLES(100),
        .CNT_W         (CNT_W)
    ) dut (
        .clk         (clk),
        .reset_l     (reset_l),
        .core_reset_l(core_reset_l),
        .done_valid  (done_valid),
        .done_pass   (done_pass),
        .done_ready  (done_ready),
        .run_count   (run_count),
        .state       (state),
        .finished    (finished),
        .passed      (passed),
        .timed_out   (timed_out)
    );

    always #5 clk = ~clk;

    function automatic exp_t mkExp(input string tag, input logic [1:0] st,
                                   input logic crl, input logic rdy,
                                   input int cnt, input logic fin,
                                   input logic pas, input logic tmo);
        exp_t e;
        e.tag = tag;
        e.st  = st;
        e.crl = crl;
        e.rdy = rdy;
        e.cnt = 32'(cnt);
        e.fin = fin;
        e.pas = pas;
        e.tmo = tmo;
        return e;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks_total++;
        if (observed === expected) begin
            checks_passed++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     tag, observed, expected, $time);
        end
    endtask

    task automatic compareNext();
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checkOutput($sformatf("%s.state", e.tag), 64'(state), 64'(e.st));
            checkOutput($sformatf("%s.core_reset_l", e.tag), 64'(core_reset_l), 64'(e.crl));
            checkOutput($sformatf("%s.done_ready", e.tag), 64'(done_ready), 64'(e.rdy));
            checkOutput($sformatf("%s.run_count", e.tag), 64'(run_count), 64'(e.cnt));
            checkOutput($sformatf("%s.finished", e.tag), 64'(finished), 64'(e.fin));
            checkOutput($sformatf("%s.passed", e.tag), 64'(passed), 64'(e.pas));
            checkOutput($sformatf("%s.timed_out", e.tag), 64'(timed_out), 64'(e.tmo));
        end
    endtask

    // Drive one cycle of inputs on the falling edge, then check after the rise.
    task automatic applyStimulus(input logic v, input logic p, input exp_t e);
        @(negedge clk);
        done_valid = v;
        done_pass  = p;
        sb.push_back(e);
        @(posedge clk);
        #1;
        compareNext();
    endtask

    // Pull reset_l low between edges and check that it acts without a clock.
    task automatic assertReset(input string tag);
        @(posedge clk);
        #3;
        reset_l    = 1'b0;
        done_valid = 1'b0;
        done_pass  = 1'b0;
        sb.push_back(mkExp(tag, ST_HOLD, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0));
        #1;
        compareNext();
    endtask

    task automatic releaseReset();
        @(posedge clk);
        #2;
        reset_l = 1'b1;
    endtask

    // Four edges after release: three in HOLD, then RUN on the fourth.
    task automatic holdSequence(input string tag, input logic v);
        for (int i = 1; i <= 3; i++) begin
            applyStimulus(v, 1'b1, mkExp($sformatf("%s_e%0d", tag, i), ST_HOLD,
                                         1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0));
        end
        applyStimulus(v, 1'b1, mkExp($sformatf("%s_e4", tag), ST_RUN,
                                     1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b0));
    endtask

    task automatic runIdle(input string tag, input int n);
        for (int k = 1; k <= n; k++) begin
            applyStimulus(1'b0, 1'b0, mkExp($sformatf("%s_c%0d", tag, k), ST_RUN,
                                             1'b1, 1'b1, k, 1'b0, 1'b0, 1'b0));
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no completion, expected finish before %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        $display("[TB] starting core_test_sequencer bench");

        // Power-on reset applied between edges.
        #2;
        reset_l = 1'b0;
        sb.push_back(mkExp("por", ST_HOLD, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0));
        #1;
        compareNext();

        // Release, with done_valid held high through HOLD (must be ignored),
        // then a passing report taken at run_count 3.
        releaseReset();
        holdSequence("t1_hold", 1'b1);
        runIdle("t2_run", 3);
        applyStimulus(1'b1, 1'b1, mkExp("t2_accept", ST_DONE, 1'b1, 1'b0, 4,
                                        1'b1, 1'b1, 1'b0));
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, mkExp($sformatf("t5_after_done%0d", i), ST_DONE,
                                            1'b1, 1'b0, 4, 1'b1, 1'b1, 1'b0));
        end

        // Timeout with no report, then frozen with reports ignored.
        assertReset("t3_reset");
        releaseReset();
        holdSequence("t3_hold", 1'b0);
        runIdle("t3_run", 99);
        applyStimulus(1'b0, 1'b0, mkExp("t3_timeout", ST_TIMEOUT, 1'b1, 1'b0, 100,
                                        1'b1, 1'b0, 1'b1));
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b1, mkExp($sformatf("t3_frozen%0d", i), ST_TIMEOUT,
                                            1'b1, 1'b0, 100, 1'b1, 1'b0, 1'b1));
        end

        // Failing report arriving on the timeout edge: transfer wins.
        assertReset("t4_reset");
        releaseReset();
        holdSequence("t4_hold", 1'b0);
        runIdle("t4_run", 99);
        applyStimulus(1'b1, 1'b0, mkExp("t4_race", ST_DONE, 1'b1, 1'b0, 100,
                                        1'b1, 1'b0, 1'b0));

        // Mid-run asynchronous reset, full HOLD repeats, then a failing report.
        assertReset("t6_reset");
        releaseReset();
        holdSequence("t6_hold", 1'b0);
        runIdle("t6_run", 10);
        assertReset("t6_midrun");
        releaseReset();
        holdSequence("t6_rehold", 1'b0);
        runIdle("t6_rerun", 2);
        applyStimulus(1'b1, 1'b0, mkExp("t6_fail", ST_DONE, 1'b1, 1'b0, 3,
                                        1'b1, 1'b0, 1'b0));

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
